uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares one UART transmitter among `NREQ` byte-stream requesters. It sits between the requester-side logic and the transmitter's serializer. A grant is held for a whole packet, ending at a `req_last` byte or a packet timeout. Bytes are handed to the transmitter one at a time with a start pulse, and the arbiter tracks the transmitter's busy flag.

---
 rtl/uart_tx_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NREQ byte-stream requesters.
// A grant is held for a whole packet and ends on an accepted req_last byte or a packet timeout.
module uart_tx_arbiter #(
   parameter int NREQ        = 4,
   parameter int DATA_W      = 8,
   parameter int ACK_TIMEOUT = 16,
   parameter int PKT_TIMEOUT = 1024
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NREQ-1:0]          req_valid,
   input  logic [NREQ*DATA_W-1:0]   req_data,
   input  logic [NREQ-1:0]          req_last,
   output logic [NREQ-1:0]          req_ready,
   output logic [NREQ-1:0]          grant,
   output logic [DATA_W-1:0]        tx_data,
   output logic                     tx_start,
   input  logic                     tx_busy,
   output logic                     err_timeout,
   output logic [1:0]               o_dbg_state
);

   localparam int PTR_W  = $clog2(NREQ);
   localparam int TMAX   = (ACK_TIMEOUT > PKT_TIMEOUT) ? ACK_TIMEOUT : PKT_TIMEOUT;
   localparam int TCNT_W = $clog2(TMAX) + 1;
   localparam logic [TCNT_W-1:0] ACK_LAST = TCNT_W'(ACK_TIMEOUT - 1);
   localparam logic [TCNT_W-1:0] PKT_LAST = TCNT_W'(PKT_TIMEOUT - 1);
   localparam logic [NREQ-1:0]   ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_ISSUE     = 2'd1,
      S_WAIT_ACK  = 2'd2,
      S_WAIT_DONE = 2'd3
   } state_t;

   state_t              r_state;
   logic [NREQ-1:0]     r_grant;
   logic [PTR_W-1:0]    r_ptr;
   logic [TCNT_W-1:0]   r_tcnt;
   logic [DATA_W-1:0]   r_tx_data;
   logic                r_tx_start;
   logic                r_err;
   logic                r_last;

   state_t              w_state_nxt;
   logic [NREQ-1:0]     w_grant_nxt;
   logic [PTR_W-1:0]    w_ptr_nxt;
   logic [TCNT_W-1:0]   w_tcnt_nxt;
   logic [DATA_W-1:0]   w_tx_data_nxt;
   logic                w_tx_start_nxt;
   logic                w_err_nxt;
   logic                w_last_nxt;

   logic [PTR_W-1:0]    w_owner;
   logic [PTR_W-1:0]    w_pick;
   logic                w_pick_any;
   logic                w_hs;
   logic [DATA_W-1:0]   w_owner_data;
   logic                w_owner_last;

   always_comb begin
      w_owner = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (r_grant[i]) w_owner = PTR_W'(i);
      end
   end

   // Scan downward so the closest requester after r_ptr is the last (winning) assignment.
   always_comb begin
      w_pick     = '0;
      w_pick_any = 1'b0;
      for (int k = NREQ; k >= 1; k--) begin
         if (req_valid[(int'(r_ptr) + k) % NREQ]) begin
            w_pick     = PTR_W'((int'(r_ptr) + k) % NREQ);
            w_pick_any = 1'b1;
         end
      end
   end

   // Handshake: a byte moves on any edge where req_valid[i] and req_ready[i] are both high.
   // req_ready only ever rises for the granted owner, in ISSUE, while the transmitter is idle.
   assign req_ready    = (r_state == S_ISSUE && !tx_busy) ? (r_grant & req_valid) : '0;
   assign w_hs         = |req_ready;
   assign w_owner_data = req_data[int'(w_owner)*DATA_W +: DATA_W];
   assign w_owner_last = req_last[w_owner];

   always_comb begin
      w_state_nxt    = r_state;
      w_grant_nxt    = r_grant;
      w_ptr_nxt      = r_ptr;
      w_tcnt_nxt     = r_tcnt;
      w_tx_data_nxt  = r_tx_data;
      w_tx_start_nxt = 1'b0;
      w_err_nxt      = 1'b0;
      w_last_nxt     = r_last;
      case (r_state)
         S_IDLE: begin
            if (w_pick_any) begin
               w_grant_nxt = ONE_HOT0 << w_pick;
               w_state_nxt = S_ISSUE;
               w_tcnt_nxt  = '0;
            end
         end
         S_ISSUE: begin
            if (w_hs) begin
               w_tx_data_nxt  = w_owner_data;
               w_last_nxt     = w_owner_last;
               w_tx_start_nxt = 1'b1;
               w_state_nxt    = S_WAIT_ACK;
               w_tcnt_nxt     = '0;
            end else if (r_tcnt == PKT_LAST) begin
               w_err_nxt   = 1'b1;
               w_ptr_nxt   = w_owner;
               w_grant_nxt = '0;
               w_state_nxt = S_IDLE;
               w_tcnt_nxt  = '0;
            end else begin
               w_tcnt_nxt = r_tcnt + 1'b1;
            end
         end
         S_WAIT_ACK: begin
            if (tx_busy) begin
               w_state_nxt = S_WAIT_DONE;
               w_tcnt_nxt  = '0;
            end else if (r_tcnt == ACK_LAST) begin
               // No acknowledge: count the byte as sent and leave as WAIT_DONE would.
               w_err_nxt  = 1'b1;
               w_tcnt_nxt = '0;
               if (r_last) begin
                  w_ptr_nxt   = w_owner;
                  w_grant_nxt = '0;
                  w_state_nxt = S_IDLE;
               end else begin
                  w_state_nxt = S_ISSUE;
               end
            end else begin
               w_tcnt_nxt = r_tcnt + 1'b1;
            end
         end
         S_WAIT_DONE: begin
            if (!tx_busy) begin
               w_tcnt_nxt = '0;
               if (r_last) begin
                  w_ptr_nxt   = w_owner;
                  w_grant_nxt = '0;
                  w_state_nxt = S_IDLE;
               end else begin
                  w_state_nxt = S_ISSUE;
               end
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_grant_nxt = '0;
            w_tcnt_nxt  = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_grant    <= '0;
         r_ptr      <= PTR_W'(NREQ - 1);
         r_tcnt     <= '0;
         r_tx_data  <= '0;
         r_tx_start <= 1'b0;
         r_err      <= 1'b0;
         r_last     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_grant    <= w_grant_nxt;
         r_ptr      <= w_ptr_nxt;
         r_tcnt     <= w_tcnt_nxt;
         r_tx_data  <= w_tx_data_nxt;
         r_tx_start <= w_tx_start_nxt;
         r_err      <= w_err_nxt;
         r_last     <= w_last_nxt;
      end
   end

   assign grant       = r_grant;
   assign tx_data     = r_tx_data;
   assign tx_start    = r_tx_start;
   assign err_timeout = r_err;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: requester queues, a busy-flag transmitter model,
// a byte scoreboard keyed on {grant, tx_data}, a round-robin vector table and timing sequences.
module tb_uart_tx_arbiter;

   localparam int NREQ   = 4;
   localparam int DATA_W = 8;
   localparam int ACK_TO = 16;
   localparam int PKT_TO = 64;
   localparam int W      = NREQ + DATA_W;

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_ISSUE     = 2'd1;
   localparam logic [1:0] ST_WAIT_DONE = 2'd3;

   logic                   clk = 1'b0;
   logic                   rst = 1'b0;
   logic [NREQ-1:0]        req_valid = '0;
   logic [NREQ*DATA_W-1:0] req_data = '0;
   logic [NREQ-1:0]        req_last = '0;
   logic [NREQ-1:0]        req_ready;
   logic [NREQ-1:0]        grant;
   logic [DATA_W-1:0]      tx_data;
   logic                   tx_start;
   logic                   tx_busy = 1'b0;
   logic                   err_timeout;
   logic [1:0]             dbg_state;

   uart_tx_arbiter #(
      .NREQ(NREQ), .DATA_W(DATA_W), .ACK_TIMEOUT(ACK_TO), .PKT_TIMEOUT(PKT_TO)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
      .req_ready(req_ready), .grant(grant),
      .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
      .err_timeout(err_timeout), .o_dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int n_err    = 0;
   int tx_cnt   = 0;
   int busy_len = 10;
   bit busy_en  = 1'b1;

   logic [W-1:0]    exp_q[$];
   logic [8:0]      rq[NREQ][$];
   logic [NREQ-1:0] hs_pend = '0;

   typedef struct {
      logic [3:0]  mask;
      int          npkt;
      int          n;
      logic [31:0] order;
   } rr_vec_t;

   rr_vec_t vecs[7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic bit rq_empty();
      bit e = 1'b1;
      for (int r = 0; r < NREQ; r++) if (rq[r].size() != 0) e = 1'b0;
      return e;
   endfunction

   // Transmitter model, scoreboard monitor and requester drivers, all on the falling edge.
   always @(negedge clk) begin
      logic [W-1:0] e;
      if (!rst) tx_cnt = 0;
      else if (tx_start && busy_en) tx_cnt = busy_len;
      else if (tx_cnt > 0) tx_cnt--;
      tx_busy = (tx_cnt != 0);

      if (rst && tx_start) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_tx_start: got grant=%b data=0x%0h expected no byte", grant, tx_data);
         end else begin
            e = exp_q.pop_front();
            check("tx_byte", 32'({grant, tx_data}), 32'(e));
         end
      end
      if (rst && err_timeout) n_err++;

      for (int r = 0; r < NREQ; r++) begin
         if (hs_pend[r] && rq[r].size() > 0) void'(rq[r].pop_front());
      end
      for (int r = 0; r < NREQ; r++) begin
         if (rq[r].size() > 0) begin
            {req_last[r], req_data[r*DATA_W +: DATA_W]} = rq[r][0];
            req_valid[r] = 1'b1;
         end else begin
            req_last[r] = 1'b0;
            req_data[r*DATA_W +: DATA_W] = '0;
            req_valid[r] = 1'b0;
         end
      end
      #1;
      hs_pend = rst ? (req_valid & req_ready) : '0;
      if (rst) begin
         checks++;
         if (!$onehot0(req_ready) || ((req_ready & ~grant) != '0)) begin
            failures++;
            $display("FAIL ready_owner: got ready=%b grant=%b expected ready within grant", req_ready, grant);
         end
      end
   end

   task automatic do_reset();
      rst = 1'b0;
      for (int r = 0; r < NREQ; r++) rq[r].delete();
      exp_q.delete();
      busy_en  = 1'b1;
      busy_len = 10;
      repeat (3) tick();
      rst   = 1'b1;
      n_err = 0;
   endtask

   task automatic wait_grant(input logic [3:0] g, input bit eq, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if ((grant == g) == eq) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   task automatic wait_state(input logic [1:0] st, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (dbg_state == st) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   task automatic count_to_err(input int budget, output int k);
      k = 0;
      while (!err_timeout && k < budget) begin
         tick();
         k++;
      end
   endtask

   task automatic finish_phase(input string name, input int exp_err, input int budget);
      bit done = 1'b0;
      for (int n = 0; n < budget && !done; n++) begin
         if (exp_q.size() == 0 && rq_empty() && dbg_state == ST_IDLE && !tx_busy) done = 1'b1;
         else tick();
      end
      check($sformatf("%s_drain", name), 32'(done), 32'd1);
      check($sformatf("%s_err_count", name), 32'(n_err), 32'(exp_err));
   endtask

   initial begin
      bit ok;
      int k;

      vecs[0] = '{4'b1111, 2, 8, 32'h3210_3210};
      vecs[1] = '{4'b0110, 1, 2, 32'h0000_0021};
      vecs[2] = '{4'b1001, 1, 2, 32'h0000_0003};
      vecs[3] = '{4'b0101, 1, 2, 32'h0000_0002};
      vecs[4] = '{4'b1010, 1, 2, 32'h0000_0031};
      vecs[5] = '{4'b1011, 2, 6, 32'h0031_0310};
      vecs[6] = '{4'b0100, 1, 1, 32'h0000_0002};

      // Reset values and single-byte latency.
      do_reset();
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_tx_start", 32'(tx_start), 32'd0);
      check("rst_tx_data", 32'(tx_data), 32'd0);
      check("rst_err", 32'(err_timeout), 32'd0);
      check("rst_ready", 32'(req_ready), 32'd0);
      check("rst_state", 32'(dbg_state), 32'(ST_IDLE));

      exp_q.push_back({4'b0001, 8'h55});
      rq[0].push_back({1'b1, 8'h55});
      tick();
      check("t1_grant_latency", 32'(grant), 32'b0001);
      check("t1_ready", 32'(req_ready), 32'b0001);
      check("t1_state_issue", 32'(dbg_state), 32'(ST_ISSUE));
      tick();
      check("t1_tx_start", 32'(tx_start), 32'd1);
      check("t1_tx_data", 32'(tx_data), 32'h55);
      tick();
      check("t1_start_one_cycle", 32'(tx_start), 32'd0);
      check("t1_data_stable", 32'(tx_data), 32'h55);
      wait_grant(4'b0000, 1'b1, 40, ok);
      check("t1_release", 32'(ok), 32'd1);
      check("t1_busy_low_at_release", 32'(tx_busy), 32'd0);
      finish_phase("t1", 0, 50);

      // Round-robin vector table; the pointer carries over from one vector to the next.
      do_reset();
      for (int v = 0; v < 7; v++) begin
         for (int p = 0; p < vecs[v].npkt; p++) begin
            for (int r = 0; r < NREQ; r++) begin
               if (vecs[v].mask[r]) rq[r].push_back({1'b1, 8'(8'hA0 + r)});
            end
         end
         for (int j = 0; j < vecs[v].n; j++) begin
            logic [3:0] idx;
            idx = vecs[v].order[4*j +: 4];
            exp_q.push_back({4'b0001 << idx, 8'(8'hA0 + idx)});
         end
         finish_phase($sformatf("t2_v%0d", v), 0, 400);
      end

      // Multi-byte packet holds the grant while another requester waits.
      do_reset();
      busy_len = 4;
      exp_q.push_back({4'b0100, 8'h11});
      exp_q.push_back({4'b0100, 8'h22});
      exp_q.push_back({4'b0100, 8'h33});
      exp_q.push_back({4'b0010, 8'h77});
      rq[2].push_back({1'b0, 8'h11});
      rq[2].push_back({1'b0, 8'h22});
      rq[2].push_back({1'b1, 8'h33});
      wait_grant(4'b0100, 1'b1, 10, ok);
      check("t3_first_grant", 32'(ok), 32'd1);
      rq[1].push_back({1'b1, 8'h77});
      wait_grant(4'b0100, 1'b0, 200, ok);
      check("t3_held_until_last", 32'(ok), 32'd1);
      check("t3_bytes_before_release", 32'(exp_q.size()), 32'd1);
      check("t3_idle_gap", 32'(grant), 32'd0);
      tick();
      check("t3_next_grant", 32'(grant), 32'b0010);
      finish_phase("t3", 0, 100);

      // Transmitter never acknowledges.
      do_reset();
      busy_en = 1'b0;
      exp_q.push_back({4'b0001, 8'h5A});
      exp_q.push_back({4'b0010, 8'h5B});
      rq[0].push_back({1'b1, 8'h5A});
      rq[1].push_back({1'b1, 8'h5B});
      ok = 1'b0;
      for (int i = 0; i < 10 && !ok; i++) begin
         if (tx_start) ok = 1'b1;
         else tick();
      end
      check("t4_start_seen", 32'(ok), 32'd1);
      count_to_err(40, k);
      check("t4_ack_timeout_latency", 32'(k), 32'(ACK_TO));
      check("t4_release_after_ack_to", 32'(grant), 32'd0);
      busy_en = 1'b1;
      tick();
      check("t4_err_single", 32'(err_timeout), 32'd0);
      finish_phase("t4", 1, 100);

      // Owner stalls mid-packet: packet timeout forces release.
      do_reset();
      busy_len = 3;
      exp_q.push_back({4'b1000, 8'h01});
      exp_q.push_back({4'b1000, 8'h02});
      exp_q.push_back({4'b0001, 8'h0F});
      rq[3].push_back({1'b0, 8'h01});
      rq[3].push_back({1'b0, 8'h02});
      wait_grant(4'b1000, 1'b1, 10, ok);
      check("t5_first_grant", 32'(ok), 32'd1);
      rq[0].push_back({1'b1, 8'h0F});
      ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
         if (exp_q.size() == 1) ok = 1'b1;
         else tick();
      end
      check("t5_two_bytes", 32'(ok), 32'd1);
      wait_state(ST_ISSUE, 20, ok);
      check("t5_reissue", 32'(ok), 32'd1);
      count_to_err(PKT_TO + 20, k);
      check("t5_pkt_timeout_latency", 32'(k), 32'(PKT_TO));
      check("t5_forced_release", 32'(grant), 32'd0);
      tick();
      check("t5_next_owner", 32'(grant), 32'b0001);
      check("t5_err_single", 32'(err_timeout), 32'd0);
      finish_phase("t5", 1, 100);

      // Reset during WAIT_DONE aborts the packet.
      do_reset();
      exp_q.push_back({4'b0100, 8'hC1});
      rq[2].push_back({1'b0, 8'hC1});
      rq[2].push_back({1'b1, 8'hC2});
      wait_state(ST_WAIT_DONE, 20, ok);
      check("t6_reach_wait_done", 32'(ok), 32'd1);
      rst = 1'b0;
      tick();
      check("t6_grant", 32'(grant), 32'd0);
      check("t6_tx_start", 32'(tx_start), 32'd0);
      check("t6_tx_data", 32'(tx_data), 32'd0);
      check("t6_err", 32'(err_timeout), 32'd0);
      check("t6_ready", 32'(req_ready), 32'd0);
      check("t6_state", 32'(dbg_state), 32'(ST_IDLE));
      for (int r = 0; r < NREQ; r++) rq[r].delete();
      repeat (2) begin
         tick();
         check("t6_no_start_in_reset", 32'(tx_start), 32'd0);
      end
      rst   = 1'b1;
      n_err = 0;
      exp_q.push_back({4'b0001, 8'hD0});
      exp_q.push_back({4'b0100, 8'hD2});
      rq[0].push_back({1'b1, 8'hD0});
      rq[2].push_back({1'b1, 8'hD2});
      tick();
      check("t6_first_after_reset", 32'(grant), 32'b0001);
      finish_phase("t6", 0, 100);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish expected completion within 50000 cycles");
      $fatal(1, "watchdog expired");
   end

endmodule
